// File: rtl/ttl_priority_encoder_irq.sv
// Registered priority encoder (highest index wins) with request latching and a
// Valid/Ack handshake. Define IRQ_EDGE_CAPTURE_EN for rising-edge request capture.
module ttl_priority_encoder_irq #(
  parameter int WIDTH_IN   = 8,
  parameter int WIDTH_OUT  = $clog2(WIDTH_IN),
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable_bar,
  input  logic [WIDTH_IN-1:0]  Req,
  input  logic [WIDTH_IN-1:0]  Mask,
  input  logic                 Ack,
  output logic [WIDTH_OUT-1:0] Code,
  output logic                 Valid,
  output logic                 Group,
  output logic                 Cascade_out,
  output logic [1:0]           State_dbg
);

  // Handshake: Code is presented while Valid=1 and stays frozen until the
  // consumer samples Ack=1 at a rising Clk edge; Ack is ignored otherwise.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_IN-1:0]  pending_q, pending_d;
  logic [WIDTH_IN-1:0]  eligible;
  logic [WIDTH_OUT-1:0] code_q, code_d, enc_code;
  logic                 valid_q, valid_d;
  logic                 group_q, group_d;
  logic                 casc_q, casc_d;
  logic                 any_eligible;

  // Propagation delays only matter for a timing model; outputs here are
  // registered with zero delay, so the parameters carry no logic.
  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delay_unmodelled
  end

  assign eligible     = pending_q & ~Mask;
  assign any_eligible = |eligible;

  always_comb begin
    enc_code = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (eligible[i]) enc_code = WIDTH_OUT'(i);
    end
  end

`ifdef IRQ_EDGE_CAPTURE_EN
  logic [WIDTH_IN-1:0] req_q;
  logic [WIDTH_IN-1:0] ack_clr;

  // The set term is OR'd after the clear so a new edge on the acked line wins.
  always_comb begin
    ack_clr = '0;
    if (state_q == PRESENT && Ack) ack_clr[code_q] = 1'b1;
    pending_d = (pending_q & ~ack_clr) | (Req & ~req_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) req_q <= '0;
    else       req_q <= Req;
  end
`else
  assign pending_d = Req;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (!Enable_bar && any_eligible) begin
          code_d  = enc_code;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (Ack) begin
          valid_d = 1'b0;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign group_d = !Enable_bar && any_eligible;
  assign casc_d  = !Enable_bar && !any_eligible;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      group_q   <= 1'b0;
      casc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      group_q   <= group_d;
      casc_q    <= casc_d;
    end
  end

  assign Code        = code_q;
  assign Valid       = valid_q;
  assign Group       = group_q;
  assign Cascade_out = casc_q;
  assign State_dbg   = state_q;

endmodule

// File: tb/tb_ttl_priority_encoder_irq.sv
// Table-driven bench for ttl_priority_encoder_irq; expected outputs are queued
// as each vector is driven and popped after the edge that consumes it.
module tb_ttl_priority_encoder_irq;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_bar;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       group;
  logic       cascade_out;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       rst;
    logic       enb;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic       group;
    logic       casc;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];

  ttl_priority_encoder_irq dut (
    .Clk         (clk),
    .Reset       (rst),
    .Enable_bar  (enable_bar),
    .Req         (req),
    .Mask        (mask),
    .Ack         (ack),
    .Code        (code),
    .Valid       (valid),
    .Group       (group),
    .Cascade_out (cascade_out),
    .State_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic add(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] m,
                     input logic a, input logic v, input logic [2:0] c, input logic g,
                     input logic cs);
    vec_t t;
    t = '{rst: r, enb: e, req: rq, mask: m, ack: a, valid: v, code: c, group: g, casc: cs};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] m,
                       input logic a);
    rst        = r;
    enable_bar = e;
    req        = rq;
    mask       = m;
    ack        = a;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string name, input int idx);
    logic [5:0] exp;
    logic [5:0] act;
    act = {valid, code, group, cascade_out};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s[%0d]: no expected entry queued, act={v,code,g,c}=%b", name, idx, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s[%0d]: act {v,code,g,c}=%b exp=%b", name, idx, act, exp);
      end
    end
  endtask

  initial begin
    int lat;
    int line;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // rst enb req mask ack | valid code group casc
    add(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, 8'h24, 8'h00, 0, 0, 0, 0, 1);
    add(0, 0, 8'h24, 8'h00, 0, 1, 5, 1, 0);
    add(0, 0, 8'h24, 8'h00, 1, 0, 5, 1, 0);
    add(0, 0, 8'h04, 8'h00, 0, 0, 5, 1, 0);
    add(0, 0, 8'h04, 8'h00, 0, 1, 2, 1, 0);
    // higher-priority arrival while presenting does not pre-empt
    add(0, 0, 8'h84, 8'h00, 0, 1, 2, 1, 0);
    add(0, 0, 8'h84, 8'h00, 0, 1, 2, 1, 0);
    add(0, 0, 8'h84, 8'h00, 1, 0, 2, 1, 0);
    add(0, 0, 8'h80, 8'h00, 0, 0, 2, 1, 0);
    add(0, 0, 8'h80, 8'h00, 0, 1, 7, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 7, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 7, 0, 1);
    // mask hides line 7; unmasking before Ack still presents 7 next
    add(0, 0, 8'h81, 8'h80, 0, 0, 7, 0, 1);
    add(0, 0, 8'h81, 8'h80, 0, 1, 0, 1, 0);
    add(0, 0, 8'h81, 8'h00, 0, 1, 0, 1, 0);
    add(0, 0, 8'h80, 8'h00, 1, 0, 0, 1, 0);
    add(0, 0, 8'h80, 8'h00, 0, 0, 0, 1, 0);
    add(0, 0, 8'h80, 8'h00, 0, 1, 7, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 7, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 7, 0, 1);
    // disabled with requests pending
    add(0, 1, 8'h24, 8'h00, 0, 0, 7, 0, 0);
    add(0, 1, 8'h24, 8'h00, 0, 0, 7, 0, 0);
    add(0, 1, 8'h24, 8'h00, 0, 0, 7, 0, 0);
    add(0, 0, 8'h24, 8'h00, 0, 1, 5, 1, 0);
    // reset mid-handshake with everything pending
    add(0, 0, 8'hFF, 8'h00, 0, 1, 5, 1, 0);
    add(0, 0, 8'hFF, 8'h00, 0, 1, 5, 1, 0);
    add(1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    // Ack ignored in IDLE and HOLDOFF
    add(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1);
    add(0, 0, 8'h08, 8'h00, 1, 0, 0, 0, 1);
    add(0, 0, 8'h08, 8'h00, 1, 1, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3, 0, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1);
`ifdef IRQ_EDGE_CAPTURE_EN
    // one-cycle pulse is latched; retrigger on the Ack edge re-presents
    add(0, 0, 8'h08, 8'h00, 0, 0, 3, 0, 1);
    add(0, 0, 8'h00, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h08, 8'h00, 1, 0, 3, 1, 0);
    add(0, 0, 8'h08, 8'h00, 0, 0, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1);
    add(0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1);
`else
    // level source that keeps Req high through HOLDOFF is re-presented
    add(0, 0, 8'h08, 8'h00, 0, 0, 3, 0, 1);
    add(0, 0, 8'h08, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h08, 8'h00, 1, 0, 3, 1, 0);
    add(0, 0, 8'h08, 8'h00, 0, 0, 3, 1, 0);
    add(0, 0, 8'h08, 8'h00, 0, 1, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 1);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].enb, vecs[i].req, vecs[i].mask, vecs[i].ack);
      exp_q.push_back({vecs[i].valid, vecs[i].code, vecs[i].group, vecs[i].casc});
      @(posedge clk);
      #1;
      check_out("vec", i);
    end

    // random single lines: two-edge latency, correct code, then acknowledge
    for (int k = 0; k < 6; k++) begin
      repeat (2) @(negedge clk);
      line = $urandom_range(0, 7);
      drive(1'b0, 1'b0, 8'(1 << line), 8'h00, 1'b0);
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
          lat = c;
          break;
        end
      end
      n_vec++;
      if (lat != 2) begin
        n_err++;
        $display("FAIL latency[%0d]: line %0d valid after %0d edges (0=timeout) exp 2", k, line, lat);
      end
      exp_q.push_back({1'b1, 3'(line), 1'b1, 1'b0});
      check_out("rand_code", k);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      @(negedge clk);
      ack = 1'b0;
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
